arrow_spawner: RTL and testbench



---
 rtl/arrow_spawner.sv | 194 +++++++++++++++++++
 tb/tb_arrow_spawner.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/arrow_spawner.sv
// rtl/arrow_spawner.sv - beat-driven arrow spawn scheduler with LFSR lane pattern and spawn FIFO
//
// Counts video frames into beats. Each beat advances a Galois LFSR, forms a
// lane mask and queues it for the downstream arrow motion logic.
// Difficulty ramps by shortening the beat period every 16 beats.
//
// Optional feature macro: ARROW_SPAWNER_CHORD_EN (adds a second lane to some beats).
//
// Ports:
//   clk_i          pixel clock
//   rst_ni         synchronous active-low reset
//   frame_i        one-cycle pulse at the start of vertical blanking
//   enable_i       game running; low stops beat generation
//   spawn_ready_i  downstream accepts the FIFO head
//   spawn_valid_o  FIFO head valid
//   spawn_lane_o   lane mask at FIFO head (bit0 left, bit1 up, bit2 down, bit3 right), 0 when empty
//   beat_o         one-cycle pulse per beat
//   level_o        difficulty level 0..7
//   drop_cnt_o     spawns lost to a full FIFO, saturating at 255
module arrow_spawner #(
    parameter int unsigned BEAT_FRAMES     = 30,
    parameter int unsigned MIN_BEAT_FRAMES = 10,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       frame_i,
    input  logic       enable_i,
    input  logic       spawn_ready_i,
    output logic       spawn_valid_o,
    output logic [3:0] spawn_lane_o,
    output logic       beat_o,
    output logic [2:0] level_o,
    output logic [7:0] drop_cnt_o
);

    // FIFO_DEPTH is a power of two, at least 2.
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BF   = 16'(BEAT_FRAMES);
    localparam logic [15:0] MBF  = 16'(MIN_BEAT_FRAMES);
    // An all-zero LFSR would lock up, so a zero seed is replaced.
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_EMIT
    } state_t;

    state_t      state, state_nx;
    logic [15:0] frame_cnt;
    logic [15:0] period;
    logic [15:0] last_frame;
    logic [15:0] level_x2;
    logic [15:0] lfsr;
    logic [15:0] lfsr_nx;
    logic [3:0]  beat_cnt;
    logic [2:0]  level;
    logic [7:0]  drop_cnt;
    logic [3:0]  mask;
    logic        fire;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;

    logic [3:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Beat period with a floor; the comparison is arranged so the
    // subtraction only happens when it cannot underflow.
    always_comb begin
        level_x2 = {12'd0, level, 1'b0};
        if (BF >= level_x2 + MBF) begin
            period = BF - level_x2;
        end else begin
            period = MBF;
        end
        last_frame = (period == 16'd0) ? 16'd0 : period - 16'd1;
    end

    // >= rather than == keeps the counter safe if the period ever shrinks
    // while the count is above the new limit.
    assign fire = enable_i && frame_i && (frame_cnt >= last_frame);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            frame_cnt <= 16'd0;
        end else if (!enable_i) begin
            frame_cnt <= 16'd0;
        end else if (frame_i) begin
            frame_cnt <= fire ? 16'd0 : frame_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // EMIT is a single cycle and completes its push even if enable drops.
    always_comb begin
        state_nx = state;
        push     = 1'b0;
        beat_o   = 1'b0;
        case (state)
            S_IDLE: begin
                if (fire) begin
                    state_nx = S_EMIT;
                end else if (enable_i) begin
                    state_nx = S_COUNT;
                end
            end
            S_COUNT: begin
                if (!enable_i) begin
                    state_nx = S_IDLE;
                end else if (fire) begin
                    state_nx = S_EMIT;
                end
            end
            S_EMIT: begin
                push     = 1'b1;
                beat_o   = 1'b1;
                state_nx = enable_i ? S_COUNT : S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Galois LFSR, shift right, taps 16'hB400; the mask uses the advanced value.
    always_comb begin
        lfsr_nx = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        mask    = 4'b0001 << lfsr_nx[1:0];
`ifdef ARROW_SPAWNER_CHORD_EN
        if (lfsr_nx[7:4] == 4'd0) begin
            mask = mask | (4'b0001 << lfsr_nx[3:2]);
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lfsr     <= SEED;
            beat_cnt <= 4'd0;
            level    <= 3'd0;
        end else if (push) begin
            lfsr     <= lfsr_nx;
            beat_cnt <= beat_cnt + 4'd1;
            if (beat_cnt == 4'd15 && level != 3'd7) begin
                level <= level + 3'd1;
            end
        end
    end

    // Spawn FIFO: pointers carry an extra wrap bit to separate full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && spawn_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            drop_cnt <= 8'd0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // A pop in the same cycle frees the slot the push needs.
            if (push && (!full || pop)) begin
                wr_ptr <= wr_ptr + 1'b1;
            end else if (push && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && (!full || pop)) begin
            fifo_mem[wr_ptr[AW-1:0]] <= mask;
        end
    end

    assign spawn_valid_o = !empty;
    assign spawn_lane_o  = empty ? 4'b0000 : fifo_mem[rd_ptr[AW-1:0]];
    assign level_o       = level;
    assign drop_cnt_o    = drop_cnt;

endmodule

// File: tb/tb_arrow_spawner.sv
// tb/tb_arrow_spawner.sv - scoreboard bench for arrow_spawner against a frame/beat reference model
module tb_arrow_spawner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame;
    logic       enable;
    logic       ready;
    logic       valid;
    logic [3:0] lane;
    logic       beat;
    logic [2:0] level;
    logic [7:0] drop;
    logic       valid2;
    logic [3:0] lane2;
    logic       beat2;
    logic [2:0] level2;
    logic [7:0] drop2;

    always #5 clk = ~clk;

    arrow_spawner #(
        .BEAT_FRAMES(4), .MIN_BEAT_FRAMES(2), .FIFO_DEPTH(4), .LFSR_SEED(16'hACE1)
    ) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .frame_i(frame), .enable_i(enable),
        .spawn_ready_i(ready), .spawn_valid_o(valid), .spawn_lane_o(lane),
        .beat_o(beat), .level_o(level), .drop_cnt_o(drop)
    );

    // Seed 16'h0010 advances to 16'h0008: [7:4]=0, [3:2]=2, [1:0]=0.
    arrow_spawner #(
        .BEAT_FRAMES(4), .MIN_BEAT_FRAMES(2), .FIFO_DEPTH(4), .LFSR_SEED(16'h0010)
    ) u_chord (
        .clk_i(clk), .rst_ni(rst_n), .frame_i(frame), .enable_i(enable),
        .spawn_ready_i(ready), .spawn_valid_o(valid2), .spawn_lane_o(lane2),
        .beat_o(beat2), .level_o(level2), .drop_cnt_o(drop2)
    );

`ifdef ARROW_SPAWNER_CHORD_EN
    localparam logic [3:0] CHORD_EXP = 4'b0101;
`else
    localparam logic [3:0] CHORD_EXP = 4'b0001;
`endif

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 0;
    bit chord_seen = 0;

    // Reference model state
    logic [3:0]  exp_q[$];
    int          m_fc = 0;
    int          m_level = 0;
    int          m_beats = 0;
    int          m_drop = 0;
    bit          m_emit = 0;
    logic [15:0] m_lfsr = 16'hACE1;

    function automatic int period_of(int lvl);
        int p;
        p = 4 - 2 * lvl;
        return (p < 2) ? 2 : p;
    endfunction

    function automatic logic [15:0] lfsr_step(logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [3:0] lane_of(logic [15:0] v);
        logic [3:0] m;
        m = 4'b0001 << v[1:0];
`ifdef ARROW_SPAWNER_CHORD_EN
        if (v[7:4] == 4'd0) m = m | (4'b0001 << v[3:2]);
`endif
        return m;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Monitor: compare this cycle's outputs, then advance the model with this cycle's inputs.
    always @(negedge clk) begin
        if (chk_en) begin
            check("valid", int'(valid), (exp_q.size() > 0) ? 1 : 0);
            check("lane", int'(lane), (exp_q.size() > 0) ? int'(exp_q[0]) : 0);
            check("beat", int'(beat), int'(m_emit));
            check("level", int'(level), m_level);
            check("drop", int'(drop), m_drop);
            if (!chord_seen && rst_n && valid2 && ready) begin
                check("chord_lane", int'(lane2), int'(CHORD_EXP));
                chord_seen = 1;
            end
        end
        if (!rst_n) begin
            exp_q.delete();
            m_fc = 0; m_level = 0; m_beats = 0; m_drop = 0; m_emit = 0;
            m_lfsr = 16'hACE1;
        end else begin
            if (exp_q.size() > 0 && ready) void'(exp_q.pop_front());
            if (m_emit) begin
                m_lfsr = lfsr_step(m_lfsr);
                if (exp_q.size() < 4) exp_q.push_back(lane_of(m_lfsr));
                else if (m_drop < 255) m_drop++;
                m_beats++;
                if (m_beats % 16 == 0 && m_level < 7) m_level++;
            end
            m_emit = 0;
            if (!enable) begin
                m_fc = 0;
            end else if (frame) begin
                m_fc++;
                if (m_fc >= period_of(m_level)) begin
                    m_fc = 0;
                    m_emit = 1;
                end
            end
        end
    end

    initial begin
        int ofs;
        bit en_next;
        rst_n  = 1'b0;
        frame  = 1'b0;
        enable = 1'b0;
        ready  = 1'b0;
        @(posedge clk); #1;
        chk_en = 1;
        @(posedge clk); #1;
        rst_n  = 1'b1;
        enable = 1'b1;
        ofs = 0;
        en_next = 1'b1;
        for (int f = 0; f < 300; f++) begin
            if (f > 160) begin
                ofs = $urandom_range(1, 19);
                en_next = ($urandom % 8) != 0;
            end
            for (int c = 0; c < 20; c++) begin
                @(posedge clk); #1;
                frame = (c == 0);
                rst_n = !((f == 160 && c == 10) || (f == 250 && c == 3));
                if (f < 6) begin
                    ready = 1'b1;
                end else if (f < 26) begin
                    ready = 1'b0;
                end else if (f < 140) begin
                    ready = ($urandom % 4) != 0;
                end else if (f <= 160) begin
                    ready  = 1'b1;
                    enable = !((f == 142 && c >= 7) || (f > 142 && f < 152));
                end else begin
                    ready = ($urandom % 2) != 0;
                    if (c == ofs) enable = en_next;
                end
            end
        end
        @(posedge clk); #1;
        frame = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("chord_observed", int'(chord_seen), 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
